// File: rtl/signed_alu_seq.sv
// signed_alu_seq: handshaked signed ALU with registered results and flags.
// Single-cycle logic/arith/shift/compare ops; iterative radix-2 Booth multiply
// over WIDTH cycles producing a full 2*WIDTH signed product.
// Optional build macro: SIGNED_ALU_SAT_EN (add/sub clamp on signed overflow).
module signed_alu_seq #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       sel,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi,
   output logic             cf,
   output logic             zf,
   output logic             of,
   output logic             nf,
   output logic             err,
   output logic [TAG_W-1:0] out_tag
);
   localparam int SHW = $clog2(WIDTH);
   localparam int M   = WIDTH - 1;
   localparam logic [3:0] OP_MUL = 4'b0110;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
   state_t state;

   logic accept;
   assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
   assign accept   = in_valid & in_ready;

   // ---------------- single-cycle datapath ----------------
   logic [SHW-1:0] shamt;
   logic [WIDTH:0] add_sum, sub_sum;
   logic           add_of, sub_of;
   logic [WIDTH-1:0] shl_r;
   assign shamt   = b[SHW-1:0];
   assign add_sum = {1'b0, a} + {1'b0, b};
   assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   assign add_of  = (a[M] == b[M]) & (add_sum[M] != a[M]);
   assign sub_of  = (a[M] != b[M]) & (sub_sum[M] != a[M]);
   assign shl_r   = a << shamt;

   logic [WIDTH-1:0] alu_lo;
   logic alu_cf, alu_of, alu_zf, alu_nf, alu_err, alu_cmp;

   // Result and flags for every opcode except multiply, from the live inputs
   always_comb begin
      alu_lo  = '0;
      alu_cf  = 1'b0;
      alu_of  = 1'b0;
      alu_err = 1'b0;
      alu_cmp = 1'b0;
      case (sel)
         4'b0000: alu_lo = a & b;
         4'b0001: alu_lo = a | b;
         4'b0010: alu_lo = a ^ b;
         4'b0011: alu_lo = ~a;
         4'b0100: begin
            alu_lo = add_sum[M:0];
            alu_cf = add_sum[WIDTH];
            alu_of = add_of;
`ifdef SIGNED_ALU_SAT_EN
            if (add_of) alu_lo = a[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
`endif
         end
         4'b0101: begin
            alu_lo = sub_sum[M:0];
            alu_cf = sub_sum[WIDTH];
            alu_of = sub_of;
`ifdef SIGNED_ALU_SAT_EN
            if (sub_of) alu_lo = a[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
`endif
         end
         4'b0110: ; // multiply runs in the Booth engine
         4'b0111: alu_lo = $signed(a) >>> shamt;
         4'b1000: begin
            alu_lo = shl_r;
            alu_of = (($signed(shl_r) >>> shamt) != $signed(a));
         end
         4'b1001: begin alu_lo = {{M{1'b0}}, ($signed(a) <  $signed(b))}; alu_cmp = 1'b1; end
         4'b1010: begin alu_lo = {{M{1'b0}}, (a == b)};                   alu_cmp = 1'b1; end
         4'b1011: begin alu_lo = {{M{1'b0}}, ($signed(a) >  $signed(b))}; alu_cmp = 1'b1; end
         default: alu_err = 1'b1;
      endcase
      // Illegal ops report all flags clear, compares report truth via zf only
      alu_nf = ~alu_err & ~alu_cmp & alu_lo[M];
      alu_zf = ~alu_err & (alu_cmp ? ~alu_lo[0] : ~|alu_lo);
   end

   // ---------------- Booth multiply engine ----------------
   // acc is one bit wider than the operands so that subtracting MIN cannot overflow.
   logic [WIDTH:0]     mcand, acc, booth_sum, acc_n;
   logic [WIDTH-1:0]   mq, mq_n;
   logic               qm1;
   logic [SHW-1:0]     cnt;
   logic [TAG_W-1:0]   tag_q;
   logic [2*WIDTH-1:0] prod;

   // One radix-2 Booth step: add/sub multiplicand, then arithmetic shift right
   always_comb begin
      booth_sum = acc;
      if (mq[0] & ~qm1)      booth_sum = acc - mcand;
      else if (~mq[0] & qm1) booth_sum = acc + mcand;
      acc_n = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      mq_n  = {booth_sum[0], mq[WIDTH-1:1]};
      prod  = {acc_n[M:0], mq_n};
   end

   // Control FSM, operand capture and registered result/flag outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         res_lo    <= '0;
         res_hi    <= '0;
         cf        <= 1'b0;
         zf        <= 1'b0;
         of        <= 1'b0;
         nf        <= 1'b0;
         err       <= 1'b0;
         out_tag   <= '0;
         mcand     <= '0;
         acc       <= '0;
         mq        <= '0;
         qm1       <= 1'b0;
         cnt       <= '0;
         tag_q     <= '0;
      end else if (state == MUL) begin
         acc <= acc_n;
         mq  <= mq_n;
         qm1 <= mq[0];
         if (cnt == '0) begin
            res_lo    <= prod[M:0];
            res_hi    <= prod[2*WIDTH-1:WIDTH];
            nf        <= prod[2*WIDTH-1];
            zf        <= ~|prod;
            cf        <= 1'b0;
            of        <= 1'b0;
            out_tag   <= tag_q;
            out_valid <= 1'b1;
            state     <= DONE;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end else if (accept) begin
         err <= alu_err;
         if (sel == OP_MUL) begin
            mcand     <= {a[M], a};
            acc       <= '0;
            mq        <= b;
            qm1       <= 1'b0;
            cnt       <= SHW'(WIDTH - 1);
            tag_q     <= in_tag;
            out_valid <= 1'b0;
            state     <= MUL;
         end else begin
            res_lo    <= alu_lo;
            res_hi    <= {WIDTH{alu_lo[M]}};
            cf        <= alu_cf;
            zf        <= alu_zf;
            of        <= alu_of;
            nf        <= alu_nf;
            out_tag   <= in_tag;
            out_valid <= 1'b1;
            state     <= DONE;
         end
      end else if (state == DONE && out_ready) begin
         out_valid <= 1'b0;
         state     <= IDLE;
      end
   end
endmodule

// File: tb/tb_signed_alu_seq.sv
// Directed self-checking bench for signed_alu_seq (WIDTH=32).
module tb_signed_alu_seq;
   localparam int W = 32;
   logic          clk = 1'b0;
   logic          rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  a, b, res_lo, res_hi;
   logic [3:0]    sel, in_tag, out_tag;
   logic          cf, zf, of, nf, err;
   int            checks = 0;
   int            errors = 0;

   signed_alu_seq #(.WIDTH(W), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sel(sel), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .res_lo(res_lo), .res_hi(res_hi), .cf(cf),
      .zf(zf), .of(of), .nf(nf), .err(err), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one op, confirm it is accepted on the next edge
   task automatic issue(input logic [3:0] op, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic [3:0] t);
      in_valid = 1'b1; sel = op; a = xa; b = xb; in_tag = t;
      #1;
      chk("in_ready_at_issue", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
   endtask

   // Check a full result; flags ordered {cf,zf,of,nf}
   task automatic chk_res(input string tag, input logic [W-1:0] lo, input logic [W-1:0] hi,
                          input logic [3:0] fl, input logic e, input logic [3:0] t);
      chk({tag, "_valid"}, out_valid, 1'b1);
      chk({tag, "_lo"}, res_lo, lo);
      chk({tag, "_hi"}, res_hi, hi);
      chk({tag, "_flags"}, {cf, zf, of, nf}, fl);
      chk({tag, "_err"}, err, e);
      chk({tag, "_tag"}, out_tag, t);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 40) begin tick(); n++; end
   endtask

   initial begin
      int n;
      int seen;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; sel = '0; in_tag = '0;
      repeat (2) tick();
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_res", {res_hi, res_lo}, 64'h0);
      chk("rst_flags", {cf, zf, of, nf, err}, 5'b0);
      chk("rst_tag", out_tag, 4'h0);
      chk("rst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      tick();

      // add overflow, result one cycle after accept
      issue(4'b0100, 32'h7FFF_FFFF, 32'h1, 4'h3);
`ifdef SIGNED_ALU_SAT_EN
      chk_res("add_ovf", 32'h7FFF_FFFF, 32'h0, 4'b0010, 1'b0, 4'h3);
`else
      chk_res("add_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 4'b0011, 1'b0, 4'h3);
`endif
      tick();
      chk("consumed", out_valid, 1'b0);

      issue(4'b0101, 32'd5, 32'd5, 4'h1);
      chk_res("sub_zero", 32'h0, 32'h0, 4'b1100, 1'b0, 4'h1);
      issue(4'b0101, 32'd0, 32'd1, 4'h2);
      chk_res("sub_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0001, 1'b0, 4'h2);
      tick();

      // multiply, latency WIDTH cycles
      issue(4'b0110, 32'hFFFF_FFFD, 32'd5, 4'h6);
      wait_valid(n);
      chk("mul_latency", n, 32);
      chk_res("mul_neg", 32'hFFFF_FFF1, 32'hFFFF_FFFF, 4'b0001, 1'b0, 4'h6);
      tick();
      issue(4'b0110, 32'h8000_0000, 32'h8000_0000, 4'h7);
      wait_valid(n);
      chk("mul_min_latency", n, 32);
      chk_res("mul_min", 32'h0, 32'h4000_0000, 4'b0000, 1'b0, 4'h7);
      tick();

      // backpressure hold, then same-cycle accept on release
      out_ready = 1'b0;
      issue(4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'h9);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_res("hold", 32'h0FF0_0FF0, 32'h0, 4'b0000, 1'b0, 4'h9);
         chk("hold_in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      issue(4'b0001, 32'd1, 32'd2, 4'h5);
      chk_res("or_b2b", 32'h3, 32'h0, 4'b0000, 1'b0, 4'h5);
      tick();

      // reset in the middle of a multiply
      issue(4'b0110, 32'd7, 32'd9, 4'hA);
      repeat (9) tick();
      rst_n = 1'b0;
      tick();
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_res", {res_hi, res_lo}, 64'h0);
      chk("midrst_tag", out_tag, 4'h0);
      chk("midrst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin tick(); if (out_valid) seen++; end
      chk("no_stale", seen, 0);

      // illegal opcode, then err clears on legal ops
      issue(4'b1100, 32'h1234, 32'h5678, 4'hC);
      chk_res("illegal", 32'h0, 32'h0, 4'b0000, 1'b1, 4'hC);
      issue(4'b1000, 32'h4000_0000, 32'd1, 4'hD);
      chk_res("shl_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 4'b0011, 1'b0, 4'hD);
      issue(4'b1001, 32'hFFFF_FFFF, 32'd1, 4'hE);
      chk_res("lt", 32'h1, 32'h0, 4'b0000, 1'b0, 4'hE);
      issue(4'b0111, 32'h8000_0000, 32'h24, 4'h4);
      chk_res("shr_mask", 32'hF800_0000, 32'hFFFF_FFFF, 4'b0001, 1'b0, 4'h4);
      issue(4'b1010, 32'd7, 32'd7, 4'h8);
      chk_res("eq", 32'h1, 32'h0, 4'b0000, 1'b0, 4'h8);
      issue(4'b1011, 32'hFFFF_FFFB, 32'd3, 4'hB);
      chk_res("gt", 32'h0, 32'h0, 4'b0100, 1'b0, 4'hB);
      issue(4'b0011, 32'h0000_FFFF, 32'h0, 4'h0);
      chk_res("not", 32'hFFFF_0000, 32'hFFFF_FFFF, 4'b0001, 1'b0, 4'h0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
